// File: rtl/blink_pkg.sv
// Shared constants and helpers for the LED blink pacing stage.
package blink_pkg;
  localparam int RATE_W = 2;
  localparam logic [RATE_W-1:0] RATE_MAX = 2'd3;
  localparam int DEF_DB_CYCLES = 500000;
  localparam int DEF_BASE_HALF = 50000000;
  localparam int NUM_KEYS = 2;
  localparam int KEY_UP = 0;
  localparam int KEY_DN = 1;

  // Each rate step halves the half-period.
  function automatic logic [RATE_W-1:0] rate_shift(input logic [RATE_W-1:0] rate);
    return rate;
  endfunction
endpackage

// File: rtl/blink_rate_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, single-cycle press strobe.
module key_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic key_n,
  output logic press
);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1, sync2, level;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        // Accepting a new level; a strobe only when leaving the released state.
        level <= sync2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/blink_rate_ctrl.sv
// Rate-selectable half-period timer: debounced up/down keys pick the rate, tick/blink pace the LEDs.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int BASE_HALF = DEF_BASE_HALF,
  parameter int CNT_W     = 26,
  parameter int DB_W      = 19
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic              KEY_UP_N,
  input  logic              KEY_DN_N,
  output logic              tick,
  output logic              blink,
  output logic [RATE_W-1:0] rate_idx
);
  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_HALF);

  logic [NUM_KEYS-1:0] key_n, press;
  logic [CNT_W-1:0]    cnt, half_m1;
  logic                up_ok, dn_ok;

  assign key_n = {KEY_DN_N, KEY_UP_N};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .CLOCK_50 (CLOCK_50),
      .RST_N    (RST_N),
      .key_n    (key_n[k]),
      .press    (press[k])
    );
  end

  assign half_m1 = (BASE >> rate_shift(rate_idx)) - 1'b1;
  // Opposing presses cancel; presses at a limit are dropped entirely.
  assign up_ok = press[KEY_UP] & ~press[KEY_DN] & (rate_idx != RATE_MAX);
  assign dn_ok = press[KEY_DN] & ~press[KEY_UP] & (rate_idx != '0);

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      rate_idx <= '0;
      cnt      <= '0;
      tick     <= 1'b0;
      blink    <= 1'b1;
    end else begin
      tick <= 1'b0;
      if (up_ok) begin
        rate_idx <= rate_idx + 1'b1;
        cnt      <= '0;
      end else if (dn_ok) begin
        rate_idx <= rate_idx - 1'b1;
        cnt      <= '0;
      end else if (cnt == half_m1) begin
        cnt   <= '0;
        tick  <= 1'b1;
        blink <= ~blink;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
